dsp_mac_sequencer: RTL
======================

# dsp_mac_sequencer

Sequencer that runs the DSP48A1 slice as a length-programmable multiply-accumulate engine, computing P = Σ A[i]·B[i] (or −Σ A[i]·B[i]) over a stream of operand pairs. It sits between a valid/ready operand source and one DSP48A1 instance, and drives that instance's data, OPMODE and clock-enable inputs. It tracks the slice's internal pipeline and flags the cycle in which the final sum is present on P.

## Interface

DSP48A1 configuration required by this block:
- A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINREG=1.
- CARRYINSEL="OPMODE5", B_INPUT="DIRECT".
- D, C, PCIN, CARRYIN and all DSP RST* except RSTP are tied 0 at top level.

Parameters:
- LEN_W, 16, width of the run-length input.

Ports:
- CLK  in  1  single clock, shared with the DSP slice.
- RSTN  in  1  asynchronous, active-low reset.
- start  in  1  starts a run; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs in the run; sampled with start.
- sub  in  1  0 = accumulate, 1 = negative accumulate; sampled with start.
- abort  in  1  cancels the current run.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pair accepted when in_valid & in_ready.
- in_a, in_b  in  18 each  unsigned operands.
- dsp_a, dsp_b  out  18 each  to DSP A/B; combinational pass-through of in_a/in_b.
- dsp_opmode  out  8  to DSP OPMODE.
- dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin  out  1 each  DSP clock enables.
- dsp_rstp  out  1  DSP RSTP (synchronous P clear).
- dsp_p  in  48  DSP P output.
- res  out  48  equals dsp_p.
- res_valid  out  1  one-cycle pulse; res holds the final sum.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on start with len=0.

## Operation

States:
- IDLE: waiting for start.
- RUN: accepting pairs; cnt = pairs remaining.
- DRAIN: all pairs accepted; waiting for the pipeline to empty.

Transitions:
- IDLE→RUN on start with len≠0. Latch cnt=len and sub.
- start with len=0: stay in IDLE, pulse err.
- RUN: each accept decrements cnt. The accept that takes cnt from 1 to 0 moves to DRAIN.
- DRAIN→IDLE in the cycle res_valid is driven high.
- abort in RUN or DRAIN → IDLE next cycle, with one-cycle dsp_rstp and no res_valid. abort in IDLE is ignored.
- Priority: abort > start. start while busy is ignored.

Handshake and enables:
- in_ready = (state==RUN).
- dsp_cea = dsp_ceb = accept.
- Track two pipeline flags: s1 (pair held in A1/B1) and s2 (product held in M). Each flag carries first/last tags.
- dsp_cem = s1; dsp_cep = s2.
- dsp_ceopmode = dsp_cecarryin = 1.

OPMODE, driven in the cycle s1 is set so the OPMODE register presents it while s2 is set:
- First pair: {sub,0,0,0, 00,01} (Z=0, X=M).
- Later pairs: {sub,0,0,0, 10,01} (Z=P, X=M).
- Bits 6, 5, 4 are always 0 (pre-adder unused, carry-in 0, B direct).
- When s1=0, dsp_opmode holds its last value; CEP=0 makes it irrelevant.

Result and arithmetic:
- res_valid is registered. It is set at the edge where s2 & last & cep, so it is high in the cycle P first shows the final sum.
- Operands are unsigned. Products are 36 bits.
- The sum wraps modulo 2^48. No overflow flag. Under sub=1 the result is two's complement.

Gaps and abort:
- Gaps (in_valid=0) clear s1 for that slot. P holds because CEP=0.
- abort clears s1, s2 and cnt.

Reset values:
- All outputs 0: in_ready, busy, res_valid, err, dsp_opmode, all CEs, dsp_rstp.
- State IDLE.

## Timing

- Pair accepted in cycle t:
  - A1/B1 loaded at the end of t.
  - M loaded at the end of t+1.
  - P loaded at the end of t+2.
- Last pair accepted in cycle t → res_valid high in cycle t+3. Fixed latency of 3, independent of gaps before it.
- Throughput: one pair per cycle. A new start is accepted in the cycle after res_valid at the earliest.
- abort in cycle k:
  - dsp_rstp=1 and busy=0 in cycle k+1.
  - P reads 0 from cycle k+2.
  - An abort in the same cycle as the one that would set res_valid suppresses it.
- RSTN deassertion mid-run: restart from IDLE. P contents are undefined until the next run.

## Test plan

- len=4, sub=0, pairs (1,2),(3,4),(5,6),(7,8) back-to-back → res_valid 3 cycles after the 4th accept, res=100. dsp_opmode is 0x01 once, then 0x09.
- Same run with in_valid low for 2 cycles between pairs 2 and 3 → res=100, and res_valid 3 cycles after the last accept.
- len=2, sub=1, pairs (3,5),(2,2) → res = 2^48−19 (0xFFFF_FFFF_FFED).
- len=1, pair (0x3FFFF,0x3FFFF) → res = 0xF_FFF8_0001.
- len=0 start → err pulse, busy stays 0. Then abort after 2 of 5 accepted pairs → dsp_rstp pulse, no res_valid, busy=0 next cycle. A follow-up len=1 run with (2,3) → res=6.
- RSTN low during RUN → all outputs 0 immediately, state IDLE, in_ready=0.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Runs one DSP48A1 slice as a length-programmable (negative) multiply-accumulate engine.
// Tracks the A1/B1 -> M -> P pipeline and pulses res_valid in the cycle P holds the final sum.
module dsp_mac_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  output logic             dsp_cecarryin,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic [47:0]      res,
  output logic             res_valid,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             first_q, first_d;
  logic             s1_q, s1_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic             s2_q, s2_d;
  logic             s2_last_q, s2_last_d;
  logic [7:0]       opmode_hold_q;
  logic             res_valid_q, res_valid_d;
  logic             err_q, err_d;
  logic             rstp_q, rstp_d;
  logic             ce_on_q;

  logic             accept;
  logic             last_accept;
  logic             is_idle;
  logic             do_abort;
  logic [7:0]       opmode_now;

  assign is_idle     = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_RUN);
  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (cnt_q == LEN_W'(1));
  assign do_abort    = abort & ~is_idle;

  // First pair of a run starts from Z=0 so stale P contents never leak in.
  assign opmode_now = {sub_q, 3'b000, (s1_first_q ? 2'b00 : 2'b10), 2'b01};
  assign dsp_opmode = s1_q ? opmode_now : opmode_hold_q;

  assign dsp_a         = in_a;
  assign dsp_b         = in_b;
  assign dsp_cea       = accept;
  assign dsp_ceb       = accept;
  assign dsp_cem       = s1_q;
  assign dsp_cep       = s2_q;
  assign dsp_ceopmode  = ce_on_q;
  assign dsp_cecarryin = ce_on_q;
  assign dsp_rstp      = rstp_q;
  assign res           = dsp_p;
  assign res_valid     = res_valid_q;
  assign busy          = ~is_idle;
  assign err           = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    first_d     = first_q;
    s1_d        = accept;
    s1_first_d  = first_q;
    s1_last_d   = last_accept;
    s2_d        = s1_q;
    s2_last_d   = s1_last_q;
    res_valid_d = s2_q & s2_last_q & dsp_cep;
    err_d       = start & is_idle & (len == '0);
    rstp_d      = do_abort;

    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d = ST_RUN;
          cnt_d   = len;
          sub_d   = sub;
          first_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (last_accept) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (res_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort flushes the pipeline tags; RSTP clears P one cycle later.
    if (do_abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      first_d     = 1'b0;
      s1_d        = 1'b0;
      s1_last_d   = 1'b0;
      s2_d        = 1'b0;
      s2_last_d   = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sub_q         <= 1'b0;
      first_q       <= 1'b0;
      s1_q          <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s2_q          <= 1'b0;
      s2_last_q     <= 1'b0;
      opmode_hold_q <= 8'h00;
      res_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      rstp_q        <= 1'b0;
      ce_on_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sub_q         <= sub_d;
      first_q       <= first_d;
      s1_q          <= s1_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s2_q          <= s2_d;
      s2_last_q     <= s2_last_d;
      opmode_hold_q <= dsp_opmode;
      res_valid_q   <= res_valid_d;
      err_q         <= err_d;
      rstp_q        <= rstp_d;
      ce_on_q       <= 1'b1;
    end
  end

endmodule
